// File: rtl/sha_feeder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sha_feeder_pkg
// Brief  : Register map, CTRL values, STATUS bits and FSM states shared by
//          the SHA-256 AXI4-Lite feeder and its bus engine.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package sha_feeder_pkg;

  localparam logic [31:0] ADDR_CTRL    = 32'h0000_0020;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_0024;
  localparam logic [31:0] ADDR_BLOCK0  = 32'h0000_0040;
  localparam logic [31:0] ADDR_DIGEST0 = 32'h0000_0080;

  localparam logic [31:0] CTRL_INIT    = 32'h0000_0001;
  localparam logic [31:0] CTRL_NEXT    = 32'h0000_0002;

  localparam int          STATUS_READY_BIT = 0;
  localparam int          STATUS_VALID_BIT = 1;

  localparam logic [3:0]  WSTRB_ALL    = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_BLK  = 3'd1,
    ST_WR_CTRL = 3'd2,
    ST_POLL    = 3'd3,
    ST_RD_DIG  = 3'd4,
    ST_OUT     = 3'd5
  } state_e;

  // Byte address of 32-bit register idx in a bank starting at base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [3:0] idx);
    return base + {26'd0, idx, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha_axi_feeder_axil_master_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : axil_master_port
// Brief  : Single-outstanding AXI4-Lite read/write engine. A one-cycle
//          wr_req/rd_req starts a transaction; done pulses combinationally in
//          the cycle the B or R handshake completes, with resp_err flagging a
//          nonzero response. A new request may be issued in that same cycle.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module axil_master_port
  import sha_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_awaddr,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  input  logic [1:0]  axi_bresp,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [31:0] axi_araddr,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp
);

  logic        wr_act_q, wr_act_d;
  logic        rd_act_q, rd_act_d;
  logic        aw_q, aw_d;
  logic        w_q, w_d;
  logic        ar_q, ar_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        w_b_hs;
  logic        w_r_hs;
  logic        w_free;

  // B/R ready only once the address (and data) phases have both finished.
  assign axi_bready  = wr_act_q & ~aw_q & ~w_q;
  assign axi_rready  = rd_act_q & ~ar_q;
  assign w_b_hs      = axi_bready & axi_bvalid;
  assign w_r_hs      = axi_rready & axi_rvalid;
  assign done        = w_b_hs | w_r_hs;
  assign resp_err    = (w_b_hs & (axi_bresp != 2'b00)) | (w_r_hs & (axi_rresp != 2'b00));
  assign rdata       = axi_rdata;
  assign w_free      = (~wr_act_q & ~rd_act_q) | done;

  assign axi_awvalid = aw_q;
  assign axi_awaddr  = addr_q;
  assign axi_wvalid  = w_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = WSTRB_ALL;
  assign axi_arvalid = ar_q;
  assign axi_araddr  = addr_q;

  // Drop each valid on its own ready, retire on B/R, then accept a new request.
  always_comb begin
    wr_act_d = wr_act_q;
    rd_act_d = rd_act_q;
    aw_d     = aw_q;
    w_d      = w_q;
    ar_d     = ar_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (aw_q && axi_awready) aw_d = 1'b0;
    if (w_q  && axi_wready)  w_d  = 1'b0;
    if (ar_q && axi_arready) ar_d = 1'b0;
    if (w_b_hs) wr_act_d = 1'b0;
    if (w_r_hs) rd_act_d = 1'b0;
    if (w_free && wr_req) begin
      wr_act_d = 1'b1;
      aw_d     = 1'b1;
      w_d      = 1'b1;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
    end else if (w_free && rd_req) begin
      rd_act_d = 1'b1;
      ar_d     = 1'b1;
      addr_d   = req_addr;
    end
  end

  // Transaction state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_act_q <= 1'b0;
      rd_act_q <= 1'b0;
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      ar_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      wr_act_q <= wr_act_d;
      rd_act_q <= rd_act_d;
      aw_q     <= aw_d;
      w_q      <= w_d;
      ar_q     <= ar_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha_axi_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sha_axi_feeder
// Brief  : AXI4-Lite master feeding 512-bit blocks into a SHA-256 peripheral:
//          writes BLOCK0..15, issues init/next, polls STATUS, reads DIGEST0..7
//          after the last block and presents the 256-bit digest.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module sha_axi_feeder #(
  parameter int POLL_LIMIT = 1024
) (
  input  logic         s_axi_clk,
  input  logic         s_axi_rst,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  input  logic         msg_first,
  input  logic         msg_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
  output logic         err,
  output logic         busy,
  output logic         m_axi_BUS_A_AWVALID,
  input  logic         m_axi_BUS_A_AWREADY,
  output logic [31:0]  m_axi_BUS_A_AWADDR,
  output logic         m_axi_BUS_A_WVALID,
  input  logic         m_axi_BUS_A_WREADY,
  output logic [31:0]  m_axi_BUS_A_WDATA,
  output logic [3:0]   m_axi_BUS_A_WSTRB,
  input  logic         m_axi_BUS_A_BVALID,
  output logic         m_axi_BUS_A_BREADY,
  input  logic [1:0]   m_axi_BUS_A_BRESP,
  output logic         m_axi_BUS_A_ARVALID,
  input  logic         m_axi_BUS_A_ARREADY,
  output logic [31:0]  m_axi_BUS_A_ARADDR,
  input  logic         m_axi_BUS_A_RVALID,
  output logic         m_axi_BUS_A_RREADY,
  input  logic [31:0]  m_axi_BUS_A_RDATA,
  input  logic [1:0]   m_axi_BUS_A_RRESP
);
  import sha_feeder_pkg::*;

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_POLL_MAX = CNT_W'(POLL_LIMIT);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [2:0]         dig_idx_q, dig_idx_d;
  logic [CNT_W-1:0]   poll_q, poll_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               inflight_q, inflight_d;
  logic               err_q, err_d;
  logic [255:0]       dig_q, dig_d;

  logic               p_wr_req;
  logic               p_rd_req;
  logic [31:0]        p_addr;
  logic [31:0]        p_wdata;
  logic               p_done;
  logic               p_err;
  logic [31:0]        p_rdata;
  logic               w_msg_ready;

  axil_master_port u_port (
    .clk         (s_axi_clk),
    .rst         (s_axi_rst),
    .wr_req      (p_wr_req),
    .rd_req      (p_rd_req),
    .req_addr    (p_addr),
    .req_wdata   (p_wdata),
    .done        (p_done),
    .resp_err    (p_err),
    .rdata       (p_rdata),
    .axi_awvalid (m_axi_BUS_A_AWVALID),
    .axi_awready (m_axi_BUS_A_AWREADY),
    .axi_awaddr  (m_axi_BUS_A_AWADDR),
    .axi_wvalid  (m_axi_BUS_A_WVALID),
    .axi_wready  (m_axi_BUS_A_WREADY),
    .axi_wdata   (m_axi_BUS_A_WDATA),
    .axi_wstrb   (m_axi_BUS_A_WSTRB),
    .axi_bvalid  (m_axi_BUS_A_BVALID),
    .axi_bready  (m_axi_BUS_A_BREADY),
    .axi_bresp   (m_axi_BUS_A_BRESP),
    .axi_arvalid (m_axi_BUS_A_ARVALID),
    .axi_arready (m_axi_BUS_A_ARREADY),
    .axi_araddr  (m_axi_BUS_A_ARADDR),
    .axi_rvalid  (m_axi_BUS_A_RVALID),
    .axi_rready  (m_axi_BUS_A_RREADY),
    .axi_rdata   (m_axi_BUS_A_RDATA),
    .axi_rresp   (m_axi_BUS_A_RRESP)
  );

  // msg_ready must stay low while reset is held even though state is IDLE.
  assign msg_ready = w_msg_ready & ~s_axi_rst;
  assign dig_data  = dig_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);

  // Next-state and bus-request logic; a word is written directly from the
  // input so the next word can be taken in the cycle the previous B lands.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dig_idx_d   = dig_idx_q;
    poll_d      = poll_q;
    first_d     = first_q;
    last_d      = last_q;
    inflight_d  = inflight_q;
    err_d       = err_q;
    dig_d       = dig_q;
    w_msg_ready = 1'b0;
    dig_valid   = 1'b0;
    p_wr_req    = 1'b0;
    p_rd_req    = 1'b0;
    p_addr      = ADDR_BLOCK0;
    p_wdata     = msg_data;

    if (p_done) inflight_d = 1'b0;
    if (p_done && p_err) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        w_msg_ready = 1'b1;
        if (msg_valid) begin
          first_d    = msg_first;
          last_d     = msg_last;
          idx_d      = 4'd0;
          p_wr_req   = 1'b1;
          p_addr     = word_addr(ADDR_BLOCK0, 4'd0);
          inflight_d = 1'b1;
          state_d    = ST_WR_BLK;
        end
      end
      ST_WR_BLK: begin
        if (p_done && idx_q == 4'd15) begin
          state_d = ST_WR_CTRL;
        end else if (!inflight_q || p_done) begin
          w_msg_ready = 1'b1;
          if (msg_valid) begin
            idx_d      = idx_q + 4'd1;
            p_wr_req   = 1'b1;
            p_addr     = word_addr(ADDR_BLOCK0, idx_q + 4'd1);
            inflight_d = 1'b1;
          end
        end
      end
      ST_WR_CTRL: begin
        if (!inflight_q) begin
          p_wr_req   = 1'b1;
          p_addr     = ADDR_CTRL;
          p_wdata    = first_q ? CTRL_INIT : CTRL_NEXT;
          inflight_d = 1'b1;
        end else if (p_done) begin
          poll_d  = '0;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        if (!inflight_q) begin
          p_rd_req   = 1'b1;
          p_addr     = ADDR_STATUS;
          inflight_d = 1'b1;
          poll_d     = poll_q + 1'b1;
        end else if (p_done) begin
          if (p_rdata[STATUS_READY_BIT] && p_rdata[STATUS_VALID_BIT]) begin
            dig_idx_d = 3'd0;
            state_d   = last_q ? ST_RD_DIG : ST_IDLE;
          end else if (poll_q == C_POLL_MAX) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RD_DIG: begin
        if (!inflight_q) begin
          p_rd_req   = 1'b1;
          p_addr     = word_addr(ADDR_DIGEST0, {1'b0, dig_idx_q});
          inflight_d = 1'b1;
        end else if (p_done) begin
          // Shift in so DIGEST0 ends up in the top word.
          dig_d = {dig_q[223:0], p_rdata};
          if (dig_idx_q == 3'd7) state_d = ST_OUT;
          else dig_idx_d = dig_idx_q + 3'd1;
        end
      end
      ST_OUT: begin
        dig_valid = 1'b1;
        if (dig_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, flags and digest register.
  always_ff @(posedge s_axi_clk) begin
    if (s_axi_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      dig_idx_q  <= 3'd0;
      poll_q     <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      dig_q      <= 256'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dig_idx_q  <= dig_idx_d;
      poll_q     <= poll_d;
      first_q    <= first_d;
      last_q     <= last_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      dig_q      <= dig_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha_axi_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_sha_axi_feeder
// Brief  : Directed bench for sha_axi_feeder with a register-level model of
//          the SHA peripheral slave (optional random ready skew, BRESP
//          injection, stuck STATUS).
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_sha_axi_feeder;

  localparam logic [255:0] DIG_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_56  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         rst;
  logic         msg_valid, msg_ready, msg_first, msg_last;
  logic [31:0]  msg_data;
  logic         dig_valid, dig_ready;
  logic [255:0] dig_data;
  logic         err, busy;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;

  always #5 clk = ~clk;

  sha_axi_feeder #(.POLL_LIMIT(4)) dut (
    .s_axi_clk(clk), .s_axi_rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_first(msg_first), .msg_last(msg_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .err(err), .busy(busy),
    .m_axi_BUS_A_AWVALID(awvalid), .m_axi_BUS_A_AWREADY(awready), .m_axi_BUS_A_AWADDR(awaddr),
    .m_axi_BUS_A_WVALID(wvalid), .m_axi_BUS_A_WREADY(wready), .m_axi_BUS_A_WDATA(wdata),
    .m_axi_BUS_A_WSTRB(wstrb),
    .m_axi_BUS_A_BVALID(bvalid), .m_axi_BUS_A_BREADY(bready), .m_axi_BUS_A_BRESP(bresp),
    .m_axi_BUS_A_ARVALID(arvalid), .m_axi_BUS_A_ARREADY(arready), .m_axi_BUS_A_ARADDR(araddr),
    .m_axi_BUS_A_RVALID(rvalid), .m_axi_BUS_A_RREADY(rready), .m_axi_BUS_A_RDATA(rdata),
    .m_axi_BUS_A_RRESP(rresp)
  );

  // ---------------- slave model ----------------
  logic        rand_mode, status_stuck, inject_bresp;
  logic        aw_rnd, w_rnd, ar_rnd;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_s, w_data_s;
  logic [31:0] dig_mem [8];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  int          status_reads;

  assign awready = aw_rnd & ~aw_got & ~bvalid;
  assign wready  = w_rnd & ~w_got & ~bvalid;
  assign arready = ar_rnd & ~rvalid;
  assign rresp   = 2'b00;

  always @(posedge clk) begin : p_slave
    logic        aw_now, w_now;
    logic [31:0] a, d;
    if (rst) begin
      aw_rnd <= 1'b1; w_rnd <= 1'b1; ar_rnd <= 1'b1;
      aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rdata <= 32'd0;
      status_reads <= 0;
    end else begin
      aw_rnd <= rand_mode ? ($urandom_range(0, 1) != 0) : 1'b1;
      w_rnd  <= rand_mode ? ($urandom_range(0, 1) != 0) : 1'b1;
      ar_rnd <= rand_mode ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (bvalid) begin
        if (bready) bvalid <= 1'b0;
      end else begin
        aw_now = aw_got | (awvalid & awready);
        w_now  = w_got | (wvalid & wready);
        if (awvalid && awready) begin aw_got <= 1'b1; aw_addr_s <= awaddr; end
        if (wvalid && wready)   begin w_got  <= 1'b1; w_data_s  <= wdata;  end
        if (aw_now && w_now) begin
          a = aw_got ? aw_addr_s : awaddr;
          d = w_got ? w_data_s : wdata;
          log_addr.push_back(a);
          log_data.push_back(d);
          if (a == 32'h20) status_reads <= 0;
          bresp  <= (inject_bresp && a == 32'h54) ? 2'b10 : 2'b00;
          bvalid <= 1'b1;
          aw_got <= 1'b0;
          w_got  <= 1'b0;
        end
      end
      if (rvalid) begin
        if (rready) rvalid <= 1'b0;
      end else if (arvalid && arready) begin
        rvalid <= 1'b1;
        if (araddr == 32'h24) begin
          rdata <= (!status_stuck && status_reads >= 2) ? 32'h3 : 32'h0;
          status_reads <= status_reads + 1;
        end else if (araddr >= 32'h80 && araddr <= 32'h9C) begin
          rdata <= dig_mem[araddr[4:2]];
        end else begin
          rdata <= 32'd0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int           cyc = 0;
  int           dv_total = 0;
  logic [255:0] dig_cap = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dig_valid) begin
      dv_total <= dv_total + 1;
      dig_cap  <= dig_data;
    end
  end

  // ---------------- helpers ----------------
  int          n_chk  = 0;
  int          n_pass = 0;
  int          t_first, t_last;
  logic [31:0] blk [16];

  task automatic chk_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic load_dig(input logic [255:0] v);
    for (int i = 0; i < 8; i++) dig_mem[i] = v[255-32*i -: 32];
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic load_56_blk1();
    blk[0]  = 32'h61626364; blk[1]  = 32'h62636465; blk[2]  = 32'h63646566; blk[3]  = 32'h64656667;
    blk[4]  = 32'h65666768; blk[5]  = 32'h66676869; blk[6]  = 32'h6768696a; blk[7]  = 32'h68696a6b;
    blk[8]  = 32'h696a6b6c; blk[9]  = 32'h6a6b6c6d; blk[10] = 32'h6b6c6d6e; blk[11] = 32'h6c6d6e6f;
    blk[12] = 32'h6d6e6f70; blk[13] = 32'h6e6f7071; blk[14] = 32'h80000000; blk[15] = 32'h00000000;
  endtask

  task automatic load_56_blk2();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[15] = 32'h000001c0;
  endtask

  // Offer n words of blk; first/last are inverted on words 1..15 to show they are ignored.
  task automatic send_block(input logic first, input logic last, input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      msg_valid = 1'b1;
      msg_data  = blk[i];
      msg_first = (i == 0) ? first : ~first;
      msg_last  = (i == 0) ? last : ~last;
      guard = 0;
      while (!msg_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) begin
        chk_val("msg_ready_timeout", 0, 1);
        msg_valid = 1'b0;
        return;
      end
      if (i == 0) t_first = cyc;
      if (i == n - 1) t_last = cyc;
      @(negedge clk);
    end
    msg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk_val("idle_in_time", (guard < 5000), 1);
  endtask

  task automatic check_writes(input string tag, input int base, input logic [31:0] ctrl);
    int bad;
    logic [31:0] ea, ed;
    bad = 0;
    chk_val({tag, "_nwrites"}, log_addr.size() - base, 17);
    if (log_addr.size() >= base + 17) begin
      for (int i = 0; i < 17; i++) begin
        ea = (i < 16) ? (32'h40 + 32'(4 * i)) : 32'h20;
        ed = (i < 16) ? blk[i] : ctrl;
        if (log_addr[base+i] !== ea || log_data[base+i] !== ed) bad++;
      end
    end else begin
      bad = 99;
    end
    chk_val({tag, "_bad_writes"}, bad, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, dv0;
    rst = 1'b1; msg_valid = 1'b0; msg_data = 32'd0; msg_first = 1'b0; msg_last = 1'b0;
    dig_ready = 1'b0; rand_mode = 1'b0; status_stuck = 1'b0; inject_bresp = 1'b0;
    load_abc();
    load_dig(DIG_ABC);

    // Reset state
    repeat (2) @(negedge clk);
    chk_val("rst_msg_ready", msg_ready, 0);
    chk_val("rst_valids", {awvalid, wvalid, bready, arvalid, rready, dig_valid}, 6'b0);
    chk_val("rst_busy_err", {busy, err}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk_val("msg_ready_after_rst", msg_ready, 1);

    // Reset mid-WR_BLK
    send_block(1'b1, 1'b1, 3);
    chk_val("midblk_busy", busy, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_val("midrst_valids", {awvalid, wvalid, bready, arvalid, rready, dig_valid}, 6'b0);
    chk_val("midrst_state", {busy, err, msg_ready}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    chk_val("midrst_ready_after", {msg_ready, busy}, 2'b10);

    // "abc" single block, zero-wait slave
    dig_ready = 1'b1;
    base = log_addr.size(); dv0 = dv_total;
    send_block(1'b1, 1'b1, 16);
    chk_val("abc_word_cadence", t_last - t_first, 30);
    wait_idle();
    check_writes("abc", base, 32'h1);
    chk_val("abc_digest", dig_cap, DIG_ABC);
    chk_val("abc_dig_valid_1cyc", dv_total - dv0, 1);
    chk_val("abc_err", err, 0);

    // 56-byte two-block message, random ready skew
    rand_mode = 1'b1;
    load_dig(DIG_56);
    load_56_blk1();
    base = log_addr.size(); dv0 = dv_total;
    send_block(1'b1, 1'b0, 16);
    wait_idle();
    check_writes("m56_b1", base, 32'h1);
    chk_val("m56_no_dv_b1", dv_total - dv0, 0);
    load_56_blk2();
    base = log_addr.size();
    send_block(1'b0, 1'b1, 16);
    wait_idle();
    check_writes("m56_b2", base, 32'h2);
    chk_val("m56_digest", dig_cap, DIG_56);
    chk_val("m56_dv_count", dv_total - dv0, 1);

    // "abc" again under random skew
    load_abc();
    load_dig(DIG_ABC);
    base = log_addr.size(); dv0 = dv_total;
    send_block(1'b1, 1'b1, 16);
    wait_idle();
    check_writes("skew", base, 32'h1);
    chk_val("skew_digest", dig_cap, DIG_ABC);
    chk_val("skew_err", err, 0);

    // BRESP error on word 5: sticky err, sequence still completes
    rand_mode = 1'b0;
    inject_bresp = 1'b1;
    base = log_addr.size(); dv0 = dv_total;
    send_block(1'b1, 1'b0, 16);
    wait_idle();
    check_writes("bresp", base, 32'h1);
    chk_val("bresp_err", err, 1);
    chk_val("bresp_no_dv", dv_total - dv0, 0);
    inject_bresp = 1'b0;
    send_block(1'b1, 1'b1, 16);
    wait_idle();
    chk_val("bresp_err_sticky", err, 1);
    chk_val("bresp_later_dv", dv_total - dv0, 1);
    do_reset();
    chk_val("err_cleared_by_rst", err, 0);

    // STATUS stuck at 0: timeout after POLL_LIMIT reads
    status_stuck = 1'b1;
    dv0 = dv_total;
    send_block(1'b1, 1'b1, 16);
    wait_idle();
    chk_val("timeout_status_reads", status_reads, 4);
    chk_val("timeout_err", err, 1);
    chk_val("timeout_no_dv", dv_total - dv0, 0);
    chk_val("timeout_msg_ready", msg_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
